// File: rtl/pong_engine.sv
// Per-frame Pong game logic plus a registered 1-bit pixel colour stage behind a VGA sync generator.
// Optional macro PONG_AI_EN: paddle 2 tracks the ball instead of following iUp2/iDn2.
module pong_engine #(
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_X1    = 16,
  parameter int PADDLE_X2    = 616,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       iclk,
  input  logic       irst_n,
  input  logic       iActive,
  input  logic [9:0] iX,
  input  logic [9:0] iY,
  input  logic       iVGA_VS,
  input  logic       iUp1,
  input  logic       iDn1,
  input  logic       iUp2,
  input  logic       iDn2,
  input  logic       iStart,
  output logic       oR,
  output logic       oG,
  output logic       oB,
  output logic [3:0] oScore1,
  output logic [3:0] oScore2,
  output logic [1:0] o_dbg_state
);

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [9:0]  C_BX0    = 10'(320 - BALL_SIZE / 2);
  localparam logic [9:0]  C_BY0    = 10'(240 - BALL_SIZE / 2);
  localparam logic [9:0]  C_PY0    = 10'(240 - PADDLE_H / 2);
  localparam logic [9:0]  C_PY_MAX = 10'(480 - PADDLE_H);
  localparam logic [9:0]  C_BY_MAX = 10'(480 - BALL_SIZE);
  localparam logic [9:0]  C_BSPD   = 10'(BALL_SPEED);
  localparam logic [9:0]  C_PSPD   = 10'(PADDLE_SPEED);
  localparam logic [9:0]  C_PX1    = 10'(PADDLE_X1);
  localparam logic [9:0]  C_PX2    = 10'(PADDLE_X2);
  localparam logic [9:0]  C_BX_L   = 10'(PADDLE_X1 + PADDLE_W);
  localparam logic [9:0]  C_BX_R   = 10'(PADDLE_X2 - BALL_SIZE);
  localparam logic [9:0]  C_HIT_L  = 10'(PADDLE_X1 + PADDLE_W + BALL_SPEED);
  localparam logic [9:0]  C_HIT_R  = 10'(PADDLE_X2 - BALL_SIZE - BALL_SPEED);
  localparam logic [9:0]  C_MISS_R = 10'(640 - BALL_SIZE - BALL_SPEED);
  localparam logic [9:0]  C_NET_LO = 10'd318;
  localparam logic [9:0]  C_NET_HI = 10'd321;
  localparam logic [10:0] C_BALL_L = 11'(BALL_SIZE);
  localparam logic [10:0] C_PH_L   = 11'(PADDLE_H);
  localparam logic [10:0] C_PW_L   = 11'(PADDLE_W);
  localparam logic [3:0]  C_WIN    = 4'(WIN_SCORE);

  typedef enum logic [1:0] {S_SERVE, S_PLAY, S_SCORED, S_GAMEOVER} state_t;

  state_t           r_state, w_state_nxt;
  logic [9:0]       r_p1y, r_p2y, r_bx, r_by;
  logic [9:0]       w_p1y_nxt, w_p2y_nxt, w_bx_nxt, w_by_nxt;
  logic             r_dx, r_dy, w_dx_nxt, w_dy_nxt;
  logic             r_scorer_p1, w_scorer_p1_nxt;
  logic [3:0]       r_s1, r_s2, w_s1_nxt, w_s2_nxt, w_s1_inc, w_s2_inc;
  logic [CNT_W-1:0] r_serve_cnt, w_serve_cnt_nxt;
  logic             r_vs_q, r_pix, w_pix, w_ft;
  logic             w_up2, w_dn2, w_hit1, w_hit2;

  function automatic logic [9:0] f_paddle(input logic [9:0] y, input logic up, input logic dn);
    logic [9:0] v;
    v = y;
    if (up && !dn)      v = (y < C_PSPD) ? 10'd0 : y - C_PSPD;
    else if (dn && !up) v = (y > C_PY_MAX - C_PSPD) ? C_PY_MAX : y + C_PSPD;
    return v;
  endfunction

  function automatic logic f_in(input logic [9:0] v, input logic [9:0] lo, input logic [10:0] len);
    return (v >= lo) && ({1'b0, v} < ({1'b0, lo} + len));
  endfunction

  function automatic logic f_overlap(input logic [9:0] a, input logic [10:0] alen,
                                     input logic [9:0] b, input logic [10:0] blen);
    return (({1'b0, a} + alen) > {1'b0, b}) && ({1'b0, a} < ({1'b0, b} + blen));
  endfunction

  assign w_ft     = r_vs_q & ~iVGA_VS;
  assign w_hit1   = f_overlap(r_by, C_BALL_L, r_p1y, C_PH_L);
  assign w_hit2   = f_overlap(r_by, C_BALL_L, r_p2y, C_PH_L);
  assign w_s1_inc = (r_s1 >= C_WIN) ? C_WIN : r_s1 + 4'd1;
  assign w_s2_inc = (r_s2 >= C_WIN) ? C_WIN : r_s2 + 4'd1;

`ifdef PONG_AI_EN
  logic [10:0] w_ball_c, w_pad_c;
  // Steer paddle 2 so its centre follows the ball centre.
  assign w_ball_c = {1'b0, r_by} + 11'(BALL_SIZE / 2);
  assign w_pad_c  = {1'b0, r_p2y} + 11'(PADDLE_H / 2);
  assign w_up2    = w_ball_c < w_pad_c;
  assign w_dn2    = w_ball_c > w_pad_c;
`else
  assign w_up2 = iUp2;
  assign w_dn2 = iDn2;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_p1y_nxt       = r_p1y;
    w_p2y_nxt       = r_p2y;
    w_bx_nxt        = r_bx;
    w_by_nxt        = r_by;
    w_dx_nxt        = r_dx;
    w_dy_nxt        = r_dy;
    w_scorer_p1_nxt = r_scorer_p1;
    w_s1_nxt        = r_s1;
    w_s2_nxt        = r_s2;
    w_serve_cnt_nxt = r_serve_cnt;
    if (w_ft) begin
      w_p1y_nxt = f_paddle(r_p1y, iUp1, iDn1);
      w_p2y_nxt = f_paddle(r_p2y, w_up2, w_dn2);
      case (r_state)
        S_SERVE: begin
          w_bx_nxt = C_BX0;
          w_by_nxt = C_BY0;
          if (r_serve_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
            w_state_nxt     = S_PLAY;
            w_serve_cnt_nxt = '0;
          end else begin
            w_serve_cnt_nxt = r_serve_cnt + 1'b1;
          end
        end
        S_PLAY: begin
          // Vertical motion always applies, including the frame a miss is detected.
          if (r_dy) begin
            if (r_by > C_BY_MAX - C_BSPD) begin
              w_by_nxt = C_BY_MAX;
              w_dy_nxt = 1'b0;
            end else begin
              w_by_nxt = r_by + C_BSPD;
            end
          end else if (r_by < C_BSPD) begin
            w_by_nxt = 10'd0;
            w_dy_nxt = 1'b1;
          end else begin
            w_by_nxt = r_by - C_BSPD;
          end
          if (!r_dx) begin
            if (r_bx <= C_HIT_L && w_hit1) begin
              w_bx_nxt = C_BX_L;
              w_dx_nxt = 1'b1;
            end else if (r_bx < C_BSPD) begin
              w_scorer_p1_nxt = 1'b0;
              w_state_nxt     = S_SCORED;
            end else begin
              w_bx_nxt = r_bx - C_BSPD;
            end
          end else begin
            if (r_bx >= C_HIT_R && w_hit2) begin
              w_bx_nxt = C_BX_R;
              w_dx_nxt = 1'b0;
            end else if (r_bx > C_MISS_R) begin
              w_scorer_p1_nxt = 1'b1;
              w_state_nxt     = S_SCORED;
            end else begin
              w_bx_nxt = r_bx + C_BSPD;
            end
          end
        end
        S_SCORED: begin
          w_bx_nxt = C_BX0;
          w_by_nxt = C_BY0;
          if (r_scorer_p1) begin
            w_s1_nxt    = w_s1_inc;
            w_dx_nxt    = 1'b1;
            w_state_nxt = (w_s1_inc == C_WIN) ? S_GAMEOVER : S_SERVE;
          end else begin
            w_s2_nxt    = w_s2_inc;
            w_dx_nxt    = 1'b0;
            w_state_nxt = (w_s2_inc == C_WIN) ? S_GAMEOVER : S_SERVE;
          end
        end
        S_GAMEOVER: begin
          if (iStart) begin
            w_s1_nxt        = 4'd0;
            w_s2_nxt        = 4'd0;
            w_serve_cnt_nxt = '0;
            w_state_nxt     = S_SERVE;
          end
        end
        default: w_state_nxt = S_SERVE;
      endcase
    end
  end

  assign w_pix = iActive && (
      (f_in(iX, C_PX1, C_PW_L) && f_in(iY, r_p1y, C_PH_L)) ||
      (f_in(iX, C_PX2, C_PW_L) && f_in(iY, r_p2y, C_PH_L)) ||
      ((r_state != S_GAMEOVER) && f_in(iX, r_bx, C_BALL_L) && f_in(iY, r_by, C_BALL_L)) ||
      ((iX >= C_NET_LO) && (iX <= C_NET_HI) && !iY[4]));

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_state     <= S_SERVE;
      r_p1y       <= C_PY0;
      r_p2y       <= C_PY0;
      r_bx        <= C_BX0;
      r_by        <= C_BY0;
      r_dx        <= 1'b1;
      r_dy        <= 1'b1;
      r_scorer_p1 <= 1'b0;
      r_s1        <= 4'd0;
      r_s2        <= 4'd0;
      r_serve_cnt <= '0;
      r_vs_q      <= 1'b1;
      r_pix       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_p1y       <= w_p1y_nxt;
      r_p2y       <= w_p2y_nxt;
      r_bx        <= w_bx_nxt;
      r_by        <= w_by_nxt;
      r_dx        <= w_dx_nxt;
      r_dy        <= w_dy_nxt;
      r_scorer_p1 <= w_scorer_p1_nxt;
      r_s1        <= w_s1_nxt;
      r_s2        <= w_s2_nxt;
      r_serve_cnt <= w_serve_cnt_nxt;
      r_vs_q      <= iVGA_VS;
      r_pix       <= w_pix;
    end
  end

  assign oR          = r_pix;
  assign oG          = r_pix;
  assign oB          = r_pix;
  assign oScore1     = r_s1;
  assign oScore2     = r_s2;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pong_engine.sv
// Randomized bench for pong_engine: a frame-level game model predicts pixel colour and scores,
// probes are queued as expectations and a monitor compares them one cycle later.
module tb_pong_engine;

  localparam int W = 11;

  logic       iclk = 1'b0;
  logic       irst_n, iActive, iVGA_VS, iUp1, iDn1, iUp2, iDn2, iStart;
  logic [9:0] iX, iY;
  logic       oR, oG, oB;
  logic [3:0] oScore1, oScore2;
  logic [1:0] o_dbg_state;

  pong_engine dut (
    .iclk(iclk), .irst_n(irst_n), .iActive(iActive), .iX(iX), .iY(iY),
    .iVGA_VS(iVGA_VS), .iUp1(iUp1), .iDn1(iDn1), .iUp2(iUp2), .iDn2(iDn2),
    .iStart(iStart), .oR(oR), .oG(oG), .oB(oB), .oScore1(oScore1),
    .oScore2(oScore2), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 iclk = ~iclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, required completion within 100000 cycles");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model (one call per frame) ----------------
  typedef enum int {PH_SERVE, PH_PLAY, PH_SCORED, PH_OVER} phase_t;
  phase_t m_ph;
  int     m_p1y, m_p2y, m_bx, m_by, m_cnt, m_scorer, m_s1, m_s2;
  bit     m_dx, m_dy;
  bit     tb_in_rst = 1'b0;

  function void model_reset();
    m_ph = PH_SERVE; m_p1y = 208; m_p2y = 208; m_bx = 316; m_by = 236;
    m_dx = 1'b1; m_dy = 1'b1; m_cnt = 0; m_scorer = 0; m_s1 = 0; m_s2 = 0;
  endfunction

  function automatic int step_paddle(int y, bit up, bit dn);
    if (up && !dn) return (y - 4 < 0) ? 0 : y - 4;
    if (dn && !up) return (y + 4 > 416) ? 416 : y + 4;
    return y;
  endfunction

  function void model_frame(bit u1, bit d1, bit u2, bit d2, bit st);
    int p1_old, p2_old, nbx, nby;
    bit au, ad;
    p1_old = m_p1y;
    p2_old = m_p2y;
`ifdef PONG_AI_EN
    au = (m_by + 4) < (m_p2y + 32);
    ad = (m_by + 4) > (m_p2y + 32);
`else
    au = u2;
    ad = d2;
`endif
    m_p1y = step_paddle(m_p1y, u1, d1);
    m_p2y = step_paddle(m_p2y, au, ad);
    case (m_ph)
      PH_SERVE: begin
        m_cnt++;
        if (m_cnt == 60) begin m_ph = PH_PLAY; m_cnt = 0; end
      end
      PH_PLAY: begin
        nby = m_by + (m_dy ? 2 : -2);
        if (nby > 472) begin nby = 472; m_dy = 1'b0; end
        else if (nby < 0) begin nby = 0; m_dy = 1'b1; end
        nbx = m_bx + (m_dx ? 2 : -2);
        if (!m_dx) begin
          if (nbx <= 24 && m_by + 8 > p1_old && m_by < p1_old + 64) begin nbx = 24; m_dx = 1'b1; end
          else if (m_bx < 2) begin nbx = m_bx; m_scorer = 2; m_ph = PH_SCORED; end
        end else begin
          if (nbx + 8 >= 616 && m_by + 8 > p2_old && m_by < p2_old + 64) begin nbx = 608; m_dx = 1'b0; end
          else if (m_bx > 630) begin nbx = m_bx; m_scorer = 1; m_ph = PH_SCORED; end
        end
        m_bx = nbx;
        m_by = nby;
      end
      PH_SCORED: begin
        if (m_scorer == 1) begin m_s1 = (m_s1 + 1 > 9) ? 9 : m_s1 + 1; m_dx = 1'b1; end
        else begin m_s2 = (m_s2 + 1 > 9) ? 9 : m_s2 + 1; m_dx = 1'b0; end
        m_bx = 316;
        m_by = 236;
        m_ph = (m_s1 == 9 || m_s2 == 9) ? PH_OVER : PH_SERVE;
      end
      PH_OVER: begin
        if (st) begin m_s1 = 0; m_s2 = 0; m_cnt = 0; m_ph = PH_SERVE; end
      end
      default: ;
    endcase
  endfunction

  function bit exp_pixel(bit act, int x, int y);
    bit hit;
    hit = 1'b0;
    if (x >= 16 && x < 24 && y >= m_p1y && y < m_p1y + 64) hit = 1'b1;
    if (x >= 616 && x < 624 && y >= m_p2y && y < m_p2y + 64) hit = 1'b1;
    if (m_ph != PH_OVER && x >= m_bx && x < m_bx + 8 && y >= m_by && y < m_by + 8) hit = 1'b1;
    if (x >= 318 && x <= 321 && ((y / 16) % 2 == 0)) hit = 1'b1;
    return act && hit;
  endfunction

  function automatic int clip(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [W-1:0] exp_q[$];
  int  n_checks = 0, n_fail = 0;
  logic probe_v = 1'b0, probe_d = 1'b0;
  bit  check_end = 1'b0, end_done = 1'b0;

  always @(posedge iclk) probe_d <= probe_v;

  always @(negedge iclk) begin
    logic [W-1:0] got, exp_v;
    if (probe_d) begin
      got = {oR, oG, oB, oScore1, oScore2};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL probe underflow: got rgb/s1/s2 %b, required no output", got);
      end else begin
        exp_v = exp_q.pop_front();
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL probe #%0d: got rgb=%b s1=%0d s2=%0d, required rgb=%b s1=%0d s2=%0d",
                   n_checks, got[10:8], got[7:4], got[3:0], exp_v[10:8], exp_v[7:4], exp_v[3:0]);
        end
      end
    end
    if (check_end && !end_done) begin
      end_done = 1'b1;
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL queue_drain: got %0d pending, required 0", exp_q.size());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic probe(input bit act, input int x, input int y);
    bit pix;
    @(negedge iclk);
    iVGA_VS = 1'b1;
    iActive = act;
    iX = 10'(x);
    iY = 10'(y);
    pix = tb_in_rst ? 1'b0 : exp_pixel(act, x, y);
    exp_q.push_back({{3{pix}}, 4'(m_s1), 4'(m_s2)});
    probe_v = 1'b1;
  endtask

  task automatic frame_probes();
    bit sel;
    int bx, by;
    probe(1'b1, clip(m_bx + int'($urandom_range(0, 11)) - 2, 0, 639),
                clip(m_by + int'($urandom_range(0, 11)) - 2, 0, 479));
    sel = bit'($urandom_range(0, 1));
    bx = sel ? 616 : 16;
    by = sel ? m_p2y : m_p1y;
    probe(1'b1, clip(bx + int'($urandom_range(0, 11)) - 2, 0, 639),
                clip(by + int'($urandom_range(0, 67)) - 2, 0, 479));
    probe(1'b1, int'($urandom_range(316, 323)), int'($urandom_range(0, 479)));
    probe($urandom_range(0, 3) != 0, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
  endtask

  task automatic frame(input bit u1, input bit d1, input bit u2, input bit d2, input bit st);
    @(negedge iclk);
    probe_v = 1'b0;
    iActive = 1'b0;
    iVGA_VS = 1'b0;
    iUp1 = u1; iDn1 = d1; iUp2 = u2; iDn2 = d2; iStart = st;
    model_frame(u1, d1, u2, d2, st);
    frame_probes();
  endtask

  function automatic bit rb();
    return $urandom_range(0, 2) == 0;
  endfunction

  task automatic reset_mid_frame();
    @(negedge iclk);
    probe_v = 1'b0;
    iActive = 1'b0;
    @(negedge iclk);
    irst_n = 1'b0;
    tb_in_rst = 1'b1;
    model_reset();
    probe(1'b1, 20, 230);
    probe(1'b1, 320, 240);
    probe(1'b1, 319, 0);
    @(negedge iclk);
    irst_n = 1'b1;
    tb_in_rst = 1'b0;
    probe_v = 1'b0;
    probe(1'b1, 320, 240);
    probe(1'b1, 20, 208);
    probe(1'b1, 20, 207);
    probe(1'b1, 620, 271);
    probe(1'b1, 620, 272);
    probe(1'b0, 320, 240);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    irst_n = 1'b0; iActive = 1'b0; iX = '0; iY = '0; iVGA_VS = 1'b1;
    iUp1 = 1'b0; iDn1 = 1'b0; iUp2 = 1'b0; iDn2 = 1'b0; iStart = 1'b0;
    model_reset();
    repeat (3) @(negedge iclk);
    irst_n = 1'b1;

    probe(1'b1, 320, 240);
    probe(1'b0, 320, 240);
    probe(1'b1, 316, 236);
    probe(1'b1, 324, 250);

    for (int f = 0; f < 70; f++) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int f = 0; f < 1000; f++) frame(rb(), rb(), rb(), rb(), $urandom_range(0, 15) == 0);

    reset_mid_frame();

    for (int f = 0; f < 60; f++) frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int f = 0; f < 5; f++) frame(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Paddle 2 parked at the top makes player 1 points frequent.
    for (int f = 0; f < 4000 && m_ph != PH_OVER; f++) frame(rb(), rb(), 1'b1, 1'b0, 1'b0);
    for (int f = 0; f < 5; f++) frame(rb(), rb(), rb(), rb(), 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 80; f++) frame(rb(), rb(), rb(), rb(), 1'b0);

    @(negedge iclk);
    probe_v = 1'b0;
    iActive = 1'b0;
    @(negedge iclk);
    @(negedge iclk);
    check_end = 1'b1;
    @(negedge iclk);
    @(negedge iclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
